hp_to_int: RTL and testbench

Multi-cycle converter from IEEE-754 half precision (fp16) to 16-bit two's-complement signed integer, the inverse-direction companion to the fp16 adder datapath. It accepts one operand over a valid/ready handshake and aligns the significand with a one-bit-per-cycle iterative shifter. It then rounds by truncation or round-to-nearest-even and returns the integer with exception flags over a second valid/ready handshake. It sits between the fp16 ALU result bus and integer consumers.

---
 rtl/hp_to_int_pkg.sv | 36 +++
 rtl/hp_to_int_if.sv | 21 ++
 rtl/hp_classify.sv | 33 +++
 rtl/hp_to_int.sv | 138 +++++++++++++
 tb/tb_hp_to_int.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/hp_to_int_pkg.sv
// Shared fp16 definitions: field widths, exception bit positions, converter FSM states
// and the classification record produced by hp_classify.
package hp_to_int_pkg;
   localparam int EXP_W    = 5;
   localparam int FRAC_W   = 10;
   localparam int EXP_BIAS = 15;
   localparam int EXP_MAX  = 31;
   localparam int INT_W    = 16;
   localparam int CNT_W    = 4;

   localparam int EXC_INVALID  = 2;
   localparam int EXC_OVERFLOW = 1;
   localparam int EXC_INEXACT  = 0;

   localparam logic [INT_W-1:0] SAT_POS = 16'h7FFF;
   localparam logic [INT_W-1:0] SAT_NEG = 16'h8000;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      ROUND = 2'd2,
      DONE  = 2'd3
   } state_t;

   typedef struct packed {
      logic              sign;
      logic [EXP_W-1:0]  exp;
      logic [FRAC_W-1:0] frac;
      logic              is_nan;
      logic              is_inf;
      logic              is_tiny;   // zero or subnormal
      logic              is_big;    // finite, |x| >= 2^15
      logic              shl;       // significand must move left
      logic [CNT_W-1:0]  count;
   } cls_t;
endpackage

// File: rtl/hp_to_int_if.sv
// Operand and result handshakes of the fp16-to-integer converter.
interface hp_to_int_if;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] hp_in;
   logic        rnd_mode;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] int_out;
   logic [2:0]  exceptions;

   modport master (
      output in_valid, hp_in, rnd_mode, out_ready,
      input  in_ready, out_valid, int_out, exceptions
   );

   modport slave (
      input  in_valid, hp_in, rnd_mode, out_ready,
      output in_ready, out_valid, int_out, exceptions
   );
endinterface

// File: rtl/hp_classify.sv
// Combinational fp16 unpack: special-case flags plus the alignment shift needed to
// place the integer point at bit 0 of a 16-bit magnitude.
module hp_classify
   import hp_to_int_pkg::*;
#(
   parameter int BIAS = 15,
   parameter int CAP  = 12
) (
   input  logic [15:0] hp,
   output cls_t        cls
);
   int unsigned e_val;

   always_comb begin
      cls         = '0;
      cls.sign    = hp[15];
      cls.exp     = hp[14:10];
      cls.frac    = hp[9:0];
      e_val       = int'(cls.exp);
      cls.is_nan  = (e_val == EXP_MAX) && (cls.frac != '0);
      cls.is_inf  = (e_val == EXP_MAX) && (cls.frac == '0);
      cls.is_tiny = (e_val == 0);
      cls.is_big  = (e_val != EXP_MAX) && (e_val >= BIAS + INT_W - 1);
      cls.shl     = (e_val >= BIAS + FRAC_W);
      // Right shifts past CAP only feed sticky, so they are clipped.
      if (cls.shl)
         cls.count = CNT_W'(e_val - BIAS - FRAC_W);
      else if (BIAS + FRAC_W - e_val > CAP)
         cls.count = CNT_W'(CAP);
      else
         cls.count = CNT_W'(BIAS + FRAC_W - e_val);
   end
endmodule

// File: rtl/hp_to_int.sv
// fp16 to signed 16-bit integer converter: iterative one-bit aligner, truncate or
// round-to-nearest-even, saturation and exception flags over valid/ready.
module hp_to_int #(
   parameter int EXP_BIAS  = hp_to_int_pkg::EXP_BIAS,
   parameter int SHIFT_CAP = 12
) (
   input logic         clk,
   input logic         rst,
   hp_to_int_if.slave  bus
);
   import hp_to_int_pkg::*;

   cls_t cls;

   hp_classify #(.BIAS(EXP_BIAS), .CAP(SHIFT_CAP)) u_classify (
      .hp  (bus.hp_in),
      .cls (cls)
   );

   state_t           state_reg, state_next;
   logic             sign_reg, sign_next;
   logic             rnd_reg, rnd_next;
   logic             shl_reg, shl_next;
   logic             guard_reg, guard_next;
   logic             sticky_reg, sticky_next;
   logic [INT_W-1:0] mag_reg, mag_next;
   logic [INT_W-1:0] res_reg, res_next;
   logic [CNT_W-1:0] count_reg, count_next;
   logic [2:0]       exc_reg, exc_next;
   logic [INT_W-1:0] rounded;
   logic             inc;

   always_comb begin
      state_next  = state_reg;
      sign_next   = sign_reg;
      rnd_next    = rnd_reg;
      shl_next    = shl_reg;
      guard_next  = guard_reg;
      sticky_next = sticky_reg;
      mag_next    = mag_reg;
      res_next    = res_reg;
      count_next  = count_reg;
      exc_next    = exc_reg;
      inc         = 1'b0;
      rounded     = mag_reg;
      case (state_reg)
         IDLE: begin
            if (bus.in_valid && bus.in_ready) begin
               sign_next = cls.sign;
               rnd_next  = bus.rnd_mode;
               exc_next  = '0;
               if (cls.is_nan) begin
                  res_next               = SAT_POS;
                  exc_next[EXC_INVALID]  = 1'b1;
                  state_next             = DONE;
               end else if (cls.is_inf) begin
                  res_next               = cls.sign ? SAT_NEG : SAT_POS;
                  exc_next[EXC_OVERFLOW] = 1'b1;
                  state_next             = DONE;
               end else if (cls.is_tiny) begin
                  res_next               = '0;
                  exc_next[EXC_INEXACT]  = (cls.frac != '0);
                  state_next             = DONE;
               end else if (cls.is_big) begin
                  // -32768 is the one big value that is exactly representable.
                  res_next               = cls.sign ? SAT_NEG : SAT_POS;
                  exc_next[EXC_OVERFLOW] = !(cls.sign && (int'(cls.exp) == EXP_MAX - 1)
                                             && (cls.frac == '0));
                  state_next             = DONE;
               end else begin
                  mag_next    = INT_W'({1'b1, cls.frac});
                  guard_next  = 1'b0;
                  sticky_next = 1'b0;
                  count_next  = cls.count;
                  shl_next    = cls.shl;
                  state_next  = (cls.count == '0) ? ROUND : SHIFT;
               end
            end
         end
         SHIFT: begin
            if (shl_reg) begin
               mag_next = mag_reg << 1;
            end else begin
               mag_next    = mag_reg >> 1;
               guard_next  = mag_reg[0];
               sticky_next = sticky_reg | guard_reg;
            end
            count_next = count_reg - CNT_W'(1);
            if (count_reg == CNT_W'(1))
               state_next = ROUND;
         end
         ROUND: begin
            inc                   = rnd_reg & guard_reg & (sticky_reg | mag_reg[0]);
            rounded               = mag_reg + INT_W'(inc);
            res_next              = sign_reg ? (~rounded + INT_W'(1)) : rounded;
            exc_next              = '0;
            exc_next[EXC_INEXACT] = guard_reg | sticky_reg;
            state_next            = DONE;
         end
         DONE: begin
            if (bus.out_ready)
               state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg  <= IDLE;
         sign_reg   <= 1'b0;
         rnd_reg    <= 1'b0;
         shl_reg    <= 1'b0;
         guard_reg  <= 1'b0;
         sticky_reg <= 1'b0;
         mag_reg    <= '0;
         res_reg    <= '0;
         count_reg  <= '0;
         exc_reg    <= '0;
      end else begin
         state_reg  <= state_next;
         sign_reg   <= sign_next;
         rnd_reg    <= rnd_next;
         shl_reg    <= shl_next;
         guard_reg  <= guard_next;
         sticky_reg <= sticky_next;
         mag_reg    <= mag_next;
         res_reg    <= res_next;
         count_reg  <= count_next;
         exc_reg    <= exc_next;
      end
   end

   assign bus.in_ready   = (state_reg == IDLE) & ~rst;
   assign bus.out_valid  = (state_reg == DONE);
   assign bus.int_out    = res_reg;
   assign bus.exceptions = exc_reg;
endmodule

// File: tb/tb_hp_to_int.sv
// Directed-vector bench for hp_to_int: conversions, rounding, specials, latency,
// backpressure and mid-operation reset, each with hand-computed expectations.
module tb_hp_to_int;
   logic clk = 1'b0;
   logic rst;
   int   n_cmp = 0;
   int   n_bad = 0;

   always #5 clk = ~clk;

   hp_to_int_if bus ();

   hp_to_int dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Drives one operand, waits (bounded) for the result; latency is the number of
   // clock edges after the accepting edge at which out_valid is first seen high.
   task automatic do_op(input logic [15:0] hp, input logic rnd, input logic hold,
                        output logic [15:0] res, output logic [2:0] exc, output int lat);
      int waited;
      @(negedge clk);
      bus.hp_in     = hp;
      bus.rnd_mode  = rnd;
      bus.out_ready = ~hold;
      bus.in_valid  = 1'b1;
      waited = 0;
      while (bus.in_ready !== 1'b1 && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      lat = 0;
      while (bus.out_valid !== 1'b1 && lat < 30) begin
         @(posedge clk);
         #1;
         lat++;
      end
      res = bus.int_out;
      exc = bus.exceptions;
      $display("op hp=%h rnd=%b -> int=%h exc=%b lat=%0d", hp, rnd, res, exc, lat);
      if (!hold) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_reset();
      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      bus.hp_in     = '0;
      bus.rnd_mode  = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      n_cmp++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL reset_in_ready: got %b expected 0", bus.in_ready); end
      n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
      n_cmp++; if (bus.int_out !== 16'h0000) begin n_bad++; $display("FAIL reset_int_out: got %h expected 0000", bus.int_out); end
      n_cmp++; if (bus.exceptions !== 3'b000) begin n_bad++; $display("FAIL reset_exc: got %b expected 000", bus.exceptions); end
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL release_in_ready: got %b expected 1", bus.in_ready); end
   endtask

   task automatic test_convert();
      logic [15:0] hv [6] = '{16'h3C00, 16'h3E00, 16'h4100, 16'hC100, 16'hBE00, 16'h6400};
      logic        rv [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
      logic [15:0] ev [6] = '{16'h0001, 16'h0002, 16'h0002, 16'hFFFE, 16'hFFFE, 16'h0400};
      logic [2:0]  xv [6] = '{3'b000, 3'b001, 3'b001, 3'b001, 3'b001, 3'b000};
      int          lv [6] = '{11, 11, 10, 10, 11, 1};
      logic [15:0] res;
      logic [2:0]  exc;
      int          lat;
      for (int i = 0; i < 6; i++) begin
         do_op(hv[i], rv[i], 1'b0, res, exc, lat);
         n_cmp++; if (res !== ev[i]) begin n_bad++; $display("FAIL convert_int[%h]: got %h expected %h", hv[i], res, ev[i]); end
         n_cmp++; if (exc !== xv[i]) begin n_bad++; $display("FAIL convert_exc[%h]: got %b expected %b", hv[i], exc, xv[i]); end
         n_cmp++; if (lat != lv[i]) begin n_bad++; $display("FAIL convert_lat[%h]: got %0d expected %0d", hv[i], lat, lv[i]); end
      end
   endtask

   task automatic test_specials();
      logic [15:0] hv [6] = '{16'h7800, 16'hF800, 16'hFC00, 16'h7E00, 16'h7BFF, 16'hFBFF};
      logic [15:0] ev [6] = '{16'h7FFF, 16'h8000, 16'h8000, 16'h7FFF, 16'h7FFF, 16'h8000};
      logic [2:0]  xv [6] = '{3'b010, 3'b000, 3'b010, 3'b100, 3'b010, 3'b010};
      logic [15:0] res;
      logic [2:0]  exc;
      int          lat;
      for (int i = 0; i < 6; i++) begin
         do_op(hv[i], 1'b1, 1'b0, res, exc, lat);
         n_cmp++; if (res !== ev[i]) begin n_bad++; $display("FAIL special_int[%h]: got %h expected %h", hv[i], res, ev[i]); end
         n_cmp++; if (exc !== xv[i]) begin n_bad++; $display("FAIL special_exc[%h]: got %b expected %b", hv[i], exc, xv[i]); end
         n_cmp++; if (lat != 0) begin n_bad++; $display("FAIL special_lat[%h]: got %0d expected 0", hv[i], lat); end
      end
   endtask

   task automatic test_small();
      logic [15:0] hv [6] = '{16'h3800, 16'h0001, 16'h8000, 16'h5BFF, 16'h3400, 16'h0400};
      logic [15:0] ev [6] = '{16'h0000, 16'h0000, 16'h0000, 16'h0100, 16'h0000, 16'h0000};
      logic [2:0]  xv [6] = '{3'b001, 3'b001, 3'b000, 3'b001, 3'b001, 3'b001};
      int          lv [6] = '{12, 0, 0, 4, 13, 13};
      logic [15:0] res;
      logic [2:0]  exc;
      int          lat;
      for (int i = 0; i < 6; i++) begin
         do_op(hv[i], 1'b1, 1'b0, res, exc, lat);
         n_cmp++; if (res !== ev[i]) begin n_bad++; $display("FAIL small_int[%h]: got %h expected %h", hv[i], res, ev[i]); end
         n_cmp++; if (exc !== xv[i]) begin n_bad++; $display("FAIL small_exc[%h]: got %b expected %b", hv[i], exc, xv[i]); end
         n_cmp++; if (lat != lv[i]) begin n_bad++; $display("FAIL small_lat[%h]: got %0d expected %0d", hv[i], lat, lv[i]); end
      end
   endtask

   task automatic test_back_to_back();
      logic [15:0] res;
      logic [2:0]  exc;
      int          lat;
      do_op(16'h7400, 1'b0, 1'b1, res, exc, lat);
      n_cmp++; if (res !== 16'h4000) begin n_bad++; $display("FAIL bp_int: got %h expected 4000", res); end
      n_cmp++; if (lat != 5) begin n_bad++; $display("FAIL bp_lat: got %0d expected 5", lat); end
      for (int c = 0; c < 5; c++) begin
         @(posedge clk);
         #1;
         n_cmp++; if (bus.int_out !== 16'h4000) begin n_bad++; $display("FAIL bp_hold_int[%0d]: got %h expected 4000", c, bus.int_out); end
         n_cmp++; if (bus.exceptions !== 3'b000) begin n_bad++; $display("FAIL bp_hold_exc[%0d]: got %b expected 000", c, bus.exceptions); end
         n_cmp++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_hold_in_ready[%0d]: got %b expected 0", c, bus.in_ready); end
         n_cmp++; if (bus.out_valid !== 1'b1) begin n_bad++; $display("FAIL bp_hold_out_valid[%0d]: got %b expected 1", c, bus.out_valid); end
      end
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_release_in_ready: got %b expected 1", bus.in_ready); end
      n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL bp_release_out_valid: got %b expected 0", bus.out_valid); end
      do_op(16'h4000, 1'b1, 1'b0, res, exc, lat);
      n_cmp++; if (res !== 16'h0002) begin n_bad++; $display("FAIL b2b_int: got %h expected 0002", res); end
      n_cmp++; if (exc !== 3'b000) begin n_bad++; $display("FAIL b2b_exc: got %b expected 000", exc); end
   endtask

   task automatic test_reset_mid();
      logic [15:0] res;
      logic [2:0]  exc;
      int          lat;
      int          seen;
      @(negedge clk);
      bus.hp_in     = 16'h3C00;
      bus.rnd_mode  = 1'b0;
      bus.out_ready = 1'b1;
      bus.in_valid  = 1'b1;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      n_cmp++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL shift_in_ready: got %b expected 0", bus.in_ready); end
      rst = 1'b1;
      #1;
      n_cmp++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL rst_mid_in_ready: got %b expected 0", bus.in_ready); end
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst  = 1'b0;
      seen = 0;
      for (int c = 0; c < 15; c++) begin
         @(posedge clk);
         #1;
         if (bus.out_valid === 1'b1) seen++;
      end
      n_cmp++; if (seen != 0) begin n_bad++; $display("FAIL rst_mid_out_valid: got %0d valid cycles expected 0", seen); end
      n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL rst_mid_in_ready_after: got %b expected 1", bus.in_ready); end
      do_op(16'h4500, 1'b0, 1'b0, res, exc, lat);
      n_cmp++; if (res !== 16'h0005) begin n_bad++; $display("FAIL fresh_int: got %h expected 0005", res); end
      n_cmp++; if (exc !== 3'b000) begin n_bad++; $display("FAIL fresh_exc: got %b expected 000", exc); end
      n_cmp++; if (lat != 9) begin n_bad++; $display("FAIL fresh_lat: got %0d expected 9", lat); end
   endtask

   initial begin
      test_reset();
      test_convert();
      test_specials();
      test_small();
      test_back_to_back();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end
endmodule
